uart_cmd_ctrl: RTL and testbench

Command sequencer between the UART RX/TX FIFO pair and the stopwatch/clock core.
- Pops received bytes from the RX FIFO one at a time and optionally echoes each byte into the TX FIFO.
- Decodes single-character commands into one-cycle control pulses.
- On '?', snapshots the clock time and streams the 10-byte report "HH:MM:SS\r\n" into the TX FIFO under tx_full backpressure.

---
 rtl/uart_cmd_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command sequencer between RX/TX FIFOs and the clock core
//
// Pops one byte at a time from the RX FIFO, optionally echoes it, decodes
// single-character commands into one-cycle pulses, and on '?' streams the
// report "HH:MM:SS\r\n" into the TX FIFO under tx_full backpressure.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rx_rdata, rx_empty, rx_rd RX FIFO head byte (fall-through), empty flag, pop pulse
//   tx_full, tx_wr, tx_wdata  TX FIFO full flag, write strobe, write data
//   hour, min, sec            current time from the clock core (binary)
//   run_pulse, clear_pulse,
//   mode_pulse                one-cycle command pulses for 'R', 'C', 'M'
//   busy                      high whenever the sequencer is not idle
module uart_cmd_ctrl #(
  parameter bit ECHO_EN  = 1'b1,
  parameter bit CASE_INS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_rdata,
  input  logic       rx_empty,
  output logic       rx_rd,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_wdata,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic       run_pulse,
  output logic       clear_pulse,
  output logic       mode_pulse,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ECHO    = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_REP_WR  = 3'd3;
  localparam logic [2:0] S_REP_GAP = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       rx_rd_q, rx_rd_d;
  logic       tx_wr_q, tx_wr_d;
  logic [7:0] tx_wdata_q, tx_wdata_d;
  logic       run_q, run_d;
  logic       clear_q, clear_d;
  logic       mode_q, mode_d;
  logic [7:0] rep_char;

  function automatic logic [7:0] dig_tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return 8'h30 + {2'b00, t};
  endfunction

  function automatic logic [7:0] dig_units(input logic [5:0] v);
    logic [5:0] u;
    u = v % 6'd10;
    return 8'h30 + {2'b00, u};
  endfunction

  // Lower case is the upper-case code with bit 5 set.
  function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] upper);
    return (b == upper) || (CASE_INS && (b == (upper | 8'h20)));
  endfunction

  // Report character for the current index, formatted from the snapshot only.
  always_comb begin
    rep_char = 8'h00;
    case (idx_q)
      4'd0:    rep_char = dig_tens({1'b0, hour_q});
      4'd1:    rep_char = dig_units({1'b0, hour_q});
      4'd2:    rep_char = 8'h3A;
      4'd3:    rep_char = dig_tens(min_q);
      4'd4:    rep_char = dig_units(min_q);
      4'd5:    rep_char = 8'h3A;
      4'd6:    rep_char = dig_tens(sec_q);
      4'd7:    rep_char = dig_units(sec_q);
      4'd8:    rep_char = 8'h0D;
      4'd9:    rep_char = 8'h0A;
      default: rep_char = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    idx_d      = idx_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    rx_rd_d    = 1'b0;
    tx_wr_d    = 1'b0;
    tx_wdata_d = tx_wdata_q;
    run_d      = 1'b0;
    clear_d    = 1'b0;
    mode_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          byte_d  = rx_rdata;
          rx_rd_d = 1'b1;
          state_d = S_ECHO;
        end
      end
      S_ECHO: begin
        // With echo enabled, stall here until the TX FIFO has room.
        if (!ECHO_EN) begin
          state_d = S_DECODE;
        end else if (!tx_full) begin
          tx_wr_d    = 1'b1;
          tx_wdata_d = byte_q;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (is_cmd(byte_q, 8'h52)) begin
          run_d = 1'b1;
        end else if (is_cmd(byte_q, 8'h43)) begin
          clear_d = 1'b1;
        end else if (is_cmd(byte_q, 8'h4D)) begin
          mode_d = 1'b1;
        end else if (byte_q == 8'h3F) begin
          hour_d  = hour;
          min_d   = min;
          sec_d   = sec;
          idx_d   = 4'd0;
          state_d = S_REP_WR;
        end
      end
      S_REP_WR: begin
        if (!tx_full) begin
          tx_wr_d    = 1'b1;
          tx_wdata_d = rep_char;
          state_d    = S_REP_GAP;
        end
      end
      S_REP_GAP: begin
        // Gap cycle lets the registered tx_full catch up with the last write.
        if (idx_q == 4'd9) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_REP_WR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_q     <= 8'h00;
      idx_q      <= 4'd0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      rx_rd_q    <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_wdata_q <= 8'h00;
      run_q      <= 1'b0;
      clear_q    <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      idx_q      <= idx_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      rx_rd_q    <= rx_rd_d;
      tx_wr_q    <= tx_wr_d;
      tx_wdata_q <= tx_wdata_d;
      run_q      <= run_d;
      clear_q    <= clear_d;
      mode_q     <= mode_d;
    end
  end

  assign rx_rd       = rx_rd_q;
  assign tx_wr       = tx_wr_q;
  assign tx_wdata    = tx_wdata_q;
  assign run_pulse   = run_q;
  assign clear_pulse = clear_q;
  assign mode_pulse  = mode_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed bench for uart_cmd_ctrl (three parameter variants in lockstep)
module tb_uart_cmd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [7:0] rx_rdata = 8'h00;
  logic       rx_empty = 1'b1;
  logic       tx_full = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [5:0] min_v = 6'd0;
  logic [5:0] sec_v = 6'd0;

  logic a_rx_rd, a_tx_wr, a_run, a_clr, a_mode, a_busy;
  logic b_rx_rd, b_tx_wr, b_run, b_clr, b_mode, b_busy;
  logic c_rx_rd, c_tx_wr, c_run, c_clr, c_mode, c_busy;
  logic [7:0] a_wdata, b_wdata, c_wdata;

  // a: echo + case-insensitive, b: echo + upper only, c: no echo + case-insensitive
  uart_cmd_ctrl #(.ECHO_EN(1'b1), .CASE_INS(1'b1)) u_a (
    .clk(clk), .rst(rst), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_rd(a_rx_rd),
    .tx_full(tx_full), .tx_wr(a_tx_wr), .tx_wdata(a_wdata), .hour(hour), .min(min_v),
    .sec(sec_v), .run_pulse(a_run), .clear_pulse(a_clr), .mode_pulse(a_mode), .busy(a_busy));
  uart_cmd_ctrl #(.ECHO_EN(1'b1), .CASE_INS(1'b0)) u_b (
    .clk(clk), .rst(rst), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_rd(b_rx_rd),
    .tx_full(tx_full), .tx_wr(b_tx_wr), .tx_wdata(b_wdata), .hour(hour), .min(min_v),
    .sec(sec_v), .run_pulse(b_run), .clear_pulse(b_clr), .mode_pulse(b_mode), .busy(b_busy));
  uart_cmd_ctrl #(.ECHO_EN(1'b0), .CASE_INS(1'b1)) u_c (
    .clk(clk), .rst(rst), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_rd(c_rx_rd),
    .tx_full(tx_full), .tx_wr(c_tx_wr), .tx_wdata(c_wdata), .hour(hour), .min(min_v),
    .sec(sec_v), .run_pulse(c_run), .clear_pulse(c_clr), .mode_pulse(c_mode), .busy(c_busy));

  // RX FIFO model: main process writes inbuf/wp, monitor owns rp and the FIFO outputs.
  logic [7:0] inbuf [0:255];
  int wp = 0;
  int rp = 0;
  logic [7:0] log_a[$];
  logic [7:0] log_c[$];
  int n_rd = 0, n_rd_adj = 0, n_wr_adj = 0, n_ovl = 0, n_lock = 0, n_mode_a = 0;
  logic prev_rd = 1'b0, prev_wr_a = 1'b0, prev_wr_c = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (a_tx_wr) log_a.push_back(a_wdata);
      if (c_tx_wr) log_c.push_back(c_wdata);
      if (a_rx_rd && prev_rd) n_rd_adj++;
      if ((a_tx_wr && prev_wr_a) || (c_tx_wr && prev_wr_c)) n_wr_adj++;
      if ($countones({a_run, a_clr, a_mode}) > 1) n_ovl++;
      if (a_mode) n_mode_a++;
      if (a_rx_rd !== b_rx_rd || a_rx_rd !== c_rx_rd || a_busy !== b_busy || a_busy !== c_busy)
        n_lock++;
      if (a_rx_rd) begin
        n_rd++;
        rp++;
      end
      prev_rd   = a_rx_rd;
      prev_wr_a = a_tx_wr;
      prev_wr_c = c_tx_wr;
      rx_empty  = (rp == wp);
      rx_rdata  = inbuf[rp[7:0]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    inbuf[wp[7:0]] = b;
    wp++;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      done = (!a_busy && !a_rx_rd && rp == wp);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: still busy after 200 cycles, want idle", name);
    end
  endtask

  task automatic wait_log_c(input string name, input int target);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      step();
      done = (log_c.size() >= target);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d TX writes after 100 cycles, want %0d", name, log_c.size(), target);
    end
  endtask

  task automatic chk_report(input string name, input int base, input logic [7:0] e [10]);
    chk({name, "_len"}, 32'(log_c.size() - base), 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_b%0d", name, k), 32'(log_c[base + k]), 32'(e[k]));
  endtask

  typedef struct {
    logic [7:0] b;
    logic [2:0] pa;
    logic [2:0] pb;
    logic [2:0] pc;
  } vec_t;

  vec_t vt [9];
  logic [7:0] rep [10];
  int la, lc, rd0, md0;

  initial begin
    // {run, clear, mode} expected for instances a, b, c
    vt[0] = '{8'h52, 3'b100, 3'b100, 3'b100};
    vt[1] = '{8'h72, 3'b100, 3'b000, 3'b100};
    vt[2] = '{8'h43, 3'b010, 3'b010, 3'b010};
    vt[3] = '{8'h63, 3'b010, 3'b000, 3'b010};
    vt[4] = '{8'h4D, 3'b001, 3'b001, 3'b001};
    vt[5] = '{8'h6D, 3'b001, 3'b000, 3'b001};
    vt[6] = '{8'h78, 3'b000, 3'b000, 3'b000};
    vt[7] = '{8'h51, 3'b000, 3'b000, 3'b000};
    vt[8] = '{8'h00, 3'b000, 3'b000, 3'b000};

    // Reset state
    step(); step(); step();
    chk("rst_rx_rd", 32'(a_rx_rd), 32'd0);
    chk("rst_tx_wr", 32'(a_tx_wr), 32'd0);
    chk("rst_wdata", 32'(a_wdata), 32'd0);
    chk("rst_busy", 32'({a_busy, c_busy}), 32'd0);
    chk("rst_pulses", 32'({a_run, a_clr, a_mode}), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("idle_empty_no_rd", 32'(n_rd), 32'd0);
    chk("idle_empty_busy", 32'(a_busy), 32'd0);

    // Single-byte vectors: pop in C1, echo in C2, pulse in C3 only
    for (int i = 0; i < 9; i++) begin
      push(vt[i].b);
      step();
      chk($sformatf("v%0d_rd", i), 32'(a_rx_rd), 32'd1);
      chk($sformatf("v%0d_busy_c1", i), 32'(a_busy), 32'd1);
      step();
      chk($sformatf("v%0d_echo_wr", i), 32'({a_tx_wr, b_tx_wr, c_tx_wr}), 32'b110);
      chk($sformatf("v%0d_echo_data", i), 32'(a_wdata), 32'(vt[i].b));
      chk($sformatf("v%0d_busy_c2", i), 32'(a_busy), 32'd1);
      chk($sformatf("v%0d_rd_c2", i), 32'(a_rx_rd), 32'd0);
      step();
      chk($sformatf("v%0d_pulse_a", i), 32'({a_run, a_clr, a_mode}), 32'(vt[i].pa));
      chk($sformatf("v%0d_pulse_b", i), 32'({b_run, b_clr, b_mode}), 32'(vt[i].pb));
      chk($sformatf("v%0d_pulse_c", i), 32'({c_run, c_clr, c_mode}), 32'(vt[i].pc));
      chk($sformatf("v%0d_busy_c3", i), 32'(a_busy), 32'd0);
      step();
      chk($sformatf("v%0d_pulse_off", i),
          32'({a_run, a_clr, a_mode, b_run, b_clr, b_mode, c_run, c_clr, c_mode}), 32'd0);
    end

    // Report 09:05:59, time changed mid-report
    hour = 5'd9; min_v = 6'd5; sec_v = 6'd59;
    la = log_a.size(); lc = log_c.size();
    push(8'h3F);
    for (int k = 0; k < 8; k++) step();
    sec_v = 6'd12; hour = 5'd20;
    wait_idle("rep1_done");
    rep = '{8'h30, 8'h39, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39, 8'h0D, 8'h0A};
    chk_report("rep1", lc, rep);
    chk("rep1_echo_q", 32'(log_a[la]), 32'h3F);
    chk("rep1_a_len", 32'(log_a.size() - la), 32'd11);
    chk("rep1_a_last", 32'(log_a[la + 10]), 32'h0A);

    // Backpressure: tx_full held 20 cycles right after index 2 is written
    hour = 5'd23; min_v = 6'd45; sec_v = 6'd7;
    la = log_a.size(); lc = log_c.size();
    push(8'h3F);
    wait_log_c("bp_reach_idx2", lc + 3);
    tx_full = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("bp_no_wr_c", 32'(log_c.size() - lc), 32'd3);
    chk("bp_no_wr_a", 32'(log_a.size() - la), 32'd4);
    chk("bp_busy", 32'(a_busy), 32'd1);
    tx_full = 1'b0;
    wait_idle("bp_done");
    rep = '{8'h32, 8'h33, 8'h3A, 8'h34, 8'h35, 8'h3A, 8'h30, 8'h37, 8'h0D, 8'h0A};
    chk_report("bp", lc, rep);

    // "M?x" back to back
    hour = 5'd12; min_v = 6'd34; sec_v = 6'd56;
    la = log_a.size(); lc = log_c.size(); rd0 = n_rd; md0 = n_mode_a;
    push(8'h4D); push(8'h3F); push(8'h78);
    wait_idle("mqx_done");
    step(); step();
    chk("mqx_rd_count", 32'(n_rd - rd0), 32'd3);
    chk("mqx_mode_count", 32'(n_mode_a - md0), 32'd1);
    rep = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
    chk_report("mqx", lc, rep);
    chk("mqx_a_len", 32'(log_a.size() - la), 32'd13);
    chk("mqx_a_m", 32'(log_a[la]), 32'h4D);
    chk("mqx_a_q", 32'(log_a[la + 1]), 32'h3F);
    for (int k = 0; k < 10; k++)
      chk($sformatf("mqx_a_b%0d", k), 32'(log_a[la + 2 + k]), 32'(rep[k]));
    chk("mqx_a_x", 32'(log_a[la + 12]), 32'h78);

    // Reset during REP_WR of index 4
    hour = 5'd1; min_v = 6'd2; sec_v = 6'd3;
    la = log_a.size(); lc = log_c.size();
    push(8'h3F);
    wait_log_c("mr_reach_idx3", lc + 4);
    rst = 1'b0;
    #1;
    chk("mr_outs_zero",
        32'({a_rx_rd, a_tx_wr, a_busy, a_run, a_clr, a_mode, c_busy, c_tx_wr}), 32'd0);
    chk("mr_wdata_zero", 32'(a_wdata), 32'd0);
    step(); step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("mr_no_more_wr", 32'(log_c.size() - lc), 32'd4);
    chk("mr_idle", 32'(a_busy), 32'd0);

    // Global properties over the whole run
    chk("rd_never_adjacent", 32'(n_rd_adj), 32'd0);
    chk("wr_never_adjacent", 32'(n_wr_adj), 32'd0);
    chk("pulses_no_overlap", 32'(n_ovl), 32'd0);
    chk("variants_lockstep", 32'(n_lock), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
